stage_loader: RTL
=================

Name: stage_loader

Overview:
- Reader and consumer of the stage ROM interface.
- On a start request it walks every row of the selected stage through the ROM's one-cycle synchronous read port and copies each 30-bit row into the brick map memory.
- It also counts the non-empty bricks, so the game controller knows when a stage is cleared.
- Sits between the game controller FSM and the stage ROM / brick map RAM.

Parameters:
- ROWS, 30, rows per stage (ROM addresses 0..ROWS-1).
- COLS, 10, bricks per row.
- CW, 3, colour bits per brick; colour 0 means empty.
- NUM_STAGES, 1, stages 0..NUM_STAGES-1 hold valid ROM content.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  load request; sampled in IDLE only.
- stage  in  2  stage to load; latched when start is accepted.
- rom_enable  out  1  ROM read enable.
- rom_addr  out  5  ROM row address.
- rom_stage  out  2  ROM stage select.
- rom_data  in  30  ROM row; valid one clock after rom_enable/rom_addr are sampled.
- wr_en  out  1  brick map write strobe.
- wr_addr  out  5  brick map row.
- wr_data  out  30  brick map row data, same field order as the ROM row.
- brick_count  out  9  running count of non-empty bricks (max 300).
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (async, active-high) drives all outputs to 0 and the state to IDLE. Reset mid-load aborts immediately; no further ROM reads or writes follow.
- All outputs are registered.
- States: IDLE, READ, DRAIN, FINISH.
- IDLE, start=1 and stage<NUM_STAGES, at edge E0:
  - latch stage, clear brick_count, busy=1;
  - rom_enable=1, rom_addr=0, rom_stage=stage;
  - go to READ.
- IDLE, start=1 and stage>=NUM_STAGES:
  - err=1 for one cycle; no ROM access; stay in IDLE.
- start while not in IDLE is ignored; the latched stage does not change.
- READ:
  - rom_addr increments by 1 each edge while rom_enable stays 1.
  - After addr ROWS-1 has been presented for one cycle, the next edge sets rom_enable=0 and rom_addr=0, and moves to DRAIN.
- Write pipeline:
  - Row k's address is sampled by the ROM at edge E(k+1).
  - At edge E(k+2) the loader registers wr_en=1, wr_addr=k, wr_data=rom_data.
  - At the same edge, brick_count += the number of CW-bit fields of rom_data that are non-zero.
  - Writes are back-to-back: wr_en stays high for exactly ROWS consecutive cycles (after E2 through after E(ROWS+1)).
- DRAIN: captures the final row (k=ROWS-1) at edge E(ROWS+1), then goes to FINISH.
- FINISH, edge E(ROWS+2):
  - wr_en=0, busy=0, done=1 for one cycle, brick_count final and held;
  - go to IDLE.
- A start on the done cycle is accepted; brick_count clears on that acceptance.
- brick_count holds its value in IDLE until the next accepted start.
- rom_addr never exceeds ROWS-1. rom_data is only sampled on cycles following an enabled read, so undefined ROM content is never written.
- Width rules:
  - per-row count is 0..COLS, 4 bits;
  - accumulation is unsigned 9-bit; no overflow is possible for ROWS*COLS<=511.

Decomposition:
- Shared package stage_pkg:
  - ROWS, COLS, CW, ROW_W=COLS*CW, ADDR_W=5, CNT_W=9;
  - EMPTY colour constant 3'b000;
  - loader state enum.
- One sub-module, row_brick_counter: combinational, ROW_W-bit row in, 4-bit count of non-EMPTY fields out. It is reused by the collision logic when it recounts a row.

Test Plan:
- Load stage 0:
  - start=1 for one cycle with stage=0;
  - exactly 30 writes, wr_addr 0..29 in order on consecutive cycles;
  - first write in the cycle after E2; done in the cycle after E32;
  - brick_count=297 (rows 7, 15 and 23 carry an empty first field);
  - row 2 wr_data has field 9 = 111 and all other fields = 001.
- Bad stage: start with stage=2 -> err=1 for one cycle, rom_enable never asserts, busy stays 0, brick_count unchanged.
- Start while busy: pulse start with stage=3 at cycle 10 of a load -> no err, load completes unchanged with 30 writes and count 297.
- Reset mid-load: assert reset after row 12 is written -> all outputs 0 immediately, no done. A following start completes normally with count 297.
- Back-to-back: start held high continuously -> a second load begins on the done cycle; brick_count reads 0 after the restart edge and reaches 297 again.
- ROM-port checker:
  - every wr_data equals the model ROM row at wr_addr;
  - rom_enable is high for exactly 30 cycles per load;
  - rom_addr is never above 29.

Source files
------------

// File: rtl/stage_pkg.sv
// Shared constants, colour encoding and loader state for the stage ROM / brick map path.
package stage_pkg;
   localparam int unsigned ROWS       = 30;
   localparam int unsigned COLS       = 10;
   localparam int unsigned CW         = 3;
   localparam int unsigned NUM_STAGES = 1;
   localparam int unsigned ROW_W      = COLS * CW;
   localparam int unsigned ADDR_W     = 5;
   localparam int unsigned CNT_W      = 9;
   localparam int unsigned STAGE_W    = 2;
   localparam int unsigned RCNT_W     = 4;

   localparam logic [CW-1:0] EMPTY = CW'(0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_FINISH
   } load_state_t;
endpackage

// File: rtl/row_brick_counter.sv
// Counts the non-empty colour fields of one brick row (combinational).
module row_brick_counter
   import stage_pkg::*;
(
   input  logic [ROW_W-1:0]  row,
   output logic [RCNT_W-1:0] count_c
);

   always_comb begin
      count_c = '0;
      for (int unsigned i = 0; i < COLS; i++) begin
         if (row[i*CW +: CW] != EMPTY) count_c = count_c + RCNT_W'(1);
      end
   end

endmodule

// File: rtl/stage_loader.sv
// Walks a stage through the synchronous stage ROM, copies every row into the
// brick map and keeps a running count of non-empty bricks.
module stage_loader
   import stage_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [STAGE_W-1:0] stage,
   output logic               rom_enable,
   output logic [ADDR_W-1:0]  rom_addr,
   output logic [STAGE_W-1:0] rom_stage,
   input  logic [ROW_W-1:0]   rom_data,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [ROW_W-1:0]   wr_data,
   output logic [CNT_W-1:0]   brick_count,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS - 1);

   load_state_t        state, state_nxt;
   logic               rom_enable_nxt;
   logic [ADDR_W-1:0]  rom_addr_nxt;
   logic [STAGE_W-1:0] rom_stage_nxt;
   logic               busy_nxt, done_nxt, err_nxt;
   logic               accept_c;
   logic               cap_valid;
   logic [ADDR_W-1:0]  cap_addr;
   logic [RCNT_W-1:0]  row_cnt_c;

   row_brick_counter u_row_count (
      .row     (rom_data),
      .count_c (row_cnt_c)
   );

   // Control FSM: next state and next values of the registered control outputs
   always_comb begin
      state_nxt      = state;
      rom_enable_nxt = 1'b0;
      rom_addr_nxt   = '0;
      rom_stage_nxt  = rom_stage;
      busy_nxt       = busy;
      done_nxt       = 1'b0;
      err_nxt        = 1'b0;
      accept_c       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (32'(stage) < NUM_STAGES) begin
                  accept_c       = 1'b1;
                  state_nxt      = S_READ;
                  rom_enable_nxt = 1'b1;
                  rom_stage_nxt  = stage;
                  busy_nxt       = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         S_READ: begin
            if (rom_addr == LAST_ADDR) begin
               state_nxt = S_DRAIN;
            end else begin
               rom_enable_nxt = 1'b1;
               rom_addr_nxt   = rom_addr + ADDR_W'(1);
            end
         end
         S_DRAIN: state_nxt = S_FINISH;
         S_FINISH: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         rom_enable <= 1'b0;
         rom_addr   <= '0;
         rom_stage  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         rom_enable <= rom_enable_nxt;
         rom_addr   <= rom_addr_nxt;
         rom_stage  <= rom_stage_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         err        <= err_nxt;
      end
   end

   // cap_valid marks an edge at which the ROM sampled an enabled read, so
   // rom_data is only captured on the cycle after a real read.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cap_valid   <= 1'b0;
         cap_addr    <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         brick_count <= '0;
      end else begin
         cap_valid <= rom_enable;
         cap_addr  <= rom_addr;
         wr_en     <= cap_valid;
         if (cap_valid) begin
            wr_addr <= cap_addr;
            wr_data <= rom_data;
         end
         if (accept_c)       brick_count <= '0;
         else if (cap_valid) brick_count <= brick_count + CNT_W'(row_cnt_c);
      end
   end

endmodule
